layer_compositor: RTL and testbench

- Parametrised, pipelined successor to the per-state layer priority mux in the game display path.
- Takes N sprite/tile layer hit flags and ROM addresses for the current pixel and selects the highest-priority visible layer (index 0 = highest).
- Adds frame-synchronous layer enables, per-layer blinking and a per-frame collision flag between two chosen layers.
- Sits between the draw_* address generators and the pixel ROM/VGA colour stage.

---
 rtl/layer_compositor.sv | 216 +++++++++++++++++++++
 tb/tb_layer_compositor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//
// Pipelined layer priority mux for the game display path. For each pixel it
// picks the highest-priority visible layer (index 0 wins) out of N_LAYERS
// sprite/tile layers and forwards that layer's pixel ROM address. Layer
// enables and blink masks are shadowed and only take effect at frame_start.
// A per-frame collision flag reports whether layers COLL_A and COLL_B
// overlapped anywhere in the previous frame.
//
// Latency: 2 cycles from inputs to pixel_addr/layer_sel/notBlank/out_valid.
// Throughput: one pixel per cycle, no stalls.
//
// Optional build macro:
//   LAYER_COMPOSITOR_COLL_COUNT_EN - adds coll_count, the number of colliding
//                                    pixels in the previous frame
//                                    (saturating at 16'hFFFF).
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   frame_start     in   one-cycle pulse on the first pixel of a frame
//   pix_valid       in   current input pixel lies in the active area
//   layer_hit       in   per-layer "object covers this pixel" flags
//   layer_addr      in   packed per-layer addresses, layer i at [i*ADDR_W +: ADDR_W]
//   layer_en_next   in   layer enables to apply from the next frame
//   blink_mask_next in   layers to blink from the next frame
//   pixel_addr      out  address of the selected layer (0 when blank)
//   notBlank        out  some visible layer was selected
//   layer_sel       out  index of the selected layer (0 when blank)
//   out_valid       out  pix_valid aligned with the outputs
//   coll_flag       out  COLL_A/COLL_B overlapped in the previous frame
//   coll_count      out  (macro only) colliding pixel count of previous frame
// -----------------------------------------------------------------------------
module layer_compositor #(
    parameter  int N_LAYERS   = 6,
    parameter  int ADDR_W     = 17,
    parameter  int BLINK_LOG2 = 3,
    parameter  int COLL_A     = 1,
    parameter  int COLL_B     = 2,
    localparam int SEL_W      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         pix_valid,
    input  logic [N_LAYERS-1:0]          layer_hit,
    input  logic [N_LAYERS*ADDR_W-1:0]   layer_addr,
    input  logic [N_LAYERS-1:0]          layer_en_next,
    input  logic [N_LAYERS-1:0]          blink_mask_next,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic                         notBlank,
    output logic [SEL_W-1:0]             layer_sel,
    output logic                         out_valid,
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
    output logic [15:0]                  coll_count,
`endif
    output logic                         coll_flag
);

    // ------------------------------------------------------------------
    // Frame-synchronous shadow state
    // ------------------------------------------------------------------
    logic [N_LAYERS-1:0]   en_active_q,    en_active_d;
    logic [N_LAYERS-1:0]   blink_active_q, blink_active_d;
    logic [BLINK_LOG2:0]   fcnt_q,         fcnt_d;
    logic                  coll_acc_q,     coll_acc_d;
    logic                  coll_flag_q,    coll_flag_d;

    // Stage 1 registers
    logic [N_LAYERS-1:0]        vis_q;
    logic [N_LAYERS*ADDR_W-1:0] addr_q;
    logic                       valid_q;

    // Stage 2 (output) registers
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic [SEL_W-1:0]  layer_sel_q,  layer_sel_d;
    logic              not_blank_q,  not_blank_d;
    logic              out_valid_q;

    logic                blink_phase;
    logic [N_LAYERS-1:0] vis;
    logic                coll_now;
    logic                found;

    // Blink phase toggles every 2^BLINK_LOG2 frames; a blinking layer is
    // hidden during the odd half-period.
    assign blink_phase = fcnt_q[BLINK_LOG2];
    assign vis         = layer_hit & en_active_q
                         & ~(blink_active_q & {N_LAYERS{blink_phase}});

    // Collision ignores blink so an invincibility blink still collides.
    assign coll_now = pix_valid
                      & layer_hit[COLL_A] & en_active_q[COLL_A]
                      & layer_hit[COLL_B] & en_active_q[COLL_B];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        en_active_d    = en_active_q;
        blink_active_d = blink_active_q;
        fcnt_d         = fcnt_q;
        coll_acc_d     = coll_acc_q | coll_now;
        coll_flag_d    = coll_flag_q;

        // The frame_start pixel itself was already evaluated with the old
        // shadow values above; the new ones apply from the next cycle.
        if (frame_start) begin
            en_active_d    = layer_en_next;
            blink_active_d = blink_mask_next;
            fcnt_d         = fcnt_q + 1'b1;
            coll_flag_d    = coll_acc_q;
            coll_acc_d     = coll_now;
        end
    end

    // Stage 2: lowest set index of vis wins.
    // NOTE: blocking assignments inside always_comb model combinational
    // ordering (found must update within the loop); sequential state below
    // uses non-blocking assignments only.
    always_comb begin
        pixel_addr_d = '0;
        layer_sel_d  = '0;
        not_blank_d  = 1'b0;
        found        = 1'b0;
        if (valid_q) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                if (!found && vis_q[i]) begin
                    found        = 1'b1;
                    pixel_addr_d = addr_q[i*ADDR_W +: ADDR_W];
                    layer_sel_d  = SEL_W'(i);
                    not_blank_d  = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            en_active_q    <= '1;
            blink_active_q <= '0;
            fcnt_q         <= '0;
            coll_acc_q     <= 1'b0;
            coll_flag_q    <= 1'b0;
            valid_q        <= 1'b0;
            pixel_addr_q   <= '0;
            layer_sel_q    <= '0;
            not_blank_q    <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            en_active_q    <= en_active_d;
            blink_active_q <= blink_active_d;
            fcnt_q         <= fcnt_d;
            coll_acc_q     <= coll_acc_d;
            coll_flag_q    <= coll_flag_d;
            valid_q        <= pix_valid;
            pixel_addr_q   <= pixel_addr_d;
            layer_sel_q    <= layer_sel_d;
            not_blank_q    <= not_blank_d;
            out_valid_q    <= valid_q;
        end
    end

    // NOTE: stage-1 datapath registers carry no reset; their contents are
    // ignored whenever valid_q is 0, which reset guarantees.
    always_ff @(posedge clk) begin
        vis_q  <= vis;
        addr_q <= layer_addr;
    end

`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
    // ------------------------------------------------------------------
    // Colliding-pixel counter (saturating)
    // ------------------------------------------------------------------
    logic [15:0] coll_cnt_q,   coll_cnt_d;
    logic [15:0] coll_count_q, coll_count_d;

    always_comb begin
        coll_count_d = coll_count_q;
        if (coll_cnt_q == 16'hFFFF) begin
            coll_cnt_d = coll_cnt_q;
        end else begin
            coll_cnt_d = coll_cnt_q + 16'(coll_now);
        end
        if (frame_start) begin
            coll_count_d = coll_cnt_q;
            coll_cnt_d   = 16'(coll_now);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_cnt_q   <= '0;
            coll_count_q <= '0;
        end else begin
            coll_cnt_q   <= coll_cnt_d;
            coll_count_q <= coll_count_d;
        end
    end

    assign coll_count = coll_count_q;
`endif

    assign pixel_addr = pixel_addr_q;
    assign layer_sel  = layer_sel_q;
    assign notBlank   = not_blank_q;
    assign out_valid  = out_valid_q;
    assign coll_flag  = coll_flag_q;

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
//
// Self-checking bench for layer_compositor with default parameters. A
// behavioural model tracks frames, shadowed enables/blink and collisions at
// the frame level and predicts every output each cycle; directed scenarios
// are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

    localparam int N  = 6;
    localparam int AW = 17;
    localparam int BL = 3;
    localparam int CA = 1;
    localparam int CB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            frame_start;
    logic            pix_valid;
    logic [N-1:0]    layer_hit;
    logic [N*AW-1:0] layer_addr;
    logic [N-1:0]    layer_en_next;
    logic [N-1:0]    blink_mask_next;
    logic [AW-1:0]   pixel_addr;
    logic            notBlank;
    logic [2:0]      layer_sel;
    logic            out_valid;
    logic            coll_flag;
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
    logic [15:0]     coll_count;
`endif

    layer_compositor #(
        .N_LAYERS  (N),
        .ADDR_W    (AW),
        .BLINK_LOG2(BL),
        .COLL_A    (CA),
        .COLL_B    (CB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .layer_hit      (layer_hit),
        .layer_addr     (layer_addr),
        .layer_en_next  (layer_en_next),
        .blink_mask_next(blink_mask_next),
        .pixel_addr     (pixel_addr),
        .notBlank       (notBlank),
        .layer_sel      (layer_sel),
        .out_valid      (out_valid),
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
        .coll_count     (coll_count),
`endif
        .coll_flag      (coll_flag)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int addr;
        int sel;
        bit nb;
        bit ov;
    } exp_t;

    exp_t   pipe0, pipe1;     // expected outputs one and two cycles ahead
    bit [N-1:0] m_en;
    bit [N-1:0] m_blink;
    int     m_frames;         // frame_start pulses seen since reset
    bit     m_acc;            // overlap seen so far in the current frame
    bit     m_flag;
    int     m_cnt;            // overlapping pixels so far in the current frame
    int     m_count;

    function automatic exp_t zero_exp();
        exp_t e;
        e.addr = 0; e.sel = 0; e.nb = 1'b0; e.ov = 1'b0;
        return e;
    endfunction

    function automatic void model_reset();
        m_en     = '1;
        m_blink  = '0;
        m_frames = 0;
        m_acc    = 1'b0;
        m_flag   = 1'b0;
        m_cnt    = 0;
        m_count  = 0;
        pipe0    = zero_exp();
        pipe1    = zero_exp();
    endfunction

    // One pixel clock: evaluate the current inputs, check the outputs due
    // now, then advance the model across the clock edge. Entered and left
    // just after a rising edge.
    task automatic tick();
        exp_t cur;
        bit   hidden_phase;
        bit   overlap;
        cur = zero_exp();
        // Blinking layers are hidden during every odd block of 2^BL frames.
        hidden_phase = ((m_frames / (1 << BL)) % 2) == 1;
        if (pix_valid) begin
            cur.ov = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (layer_hit[i] && m_en[i] && !(m_blink[i] && hidden_phase)) begin
                    cur.nb   = 1'b1;
                    cur.sel  = i;
                    cur.addr = int'(layer_addr[i*AW +: AW]);
                    break;
                end
            end
        end
        overlap = pix_valid && layer_hit[CA] && m_en[CA] && layer_hit[CB] && m_en[CB];

        @(negedge clk);
        check("pixel_addr", 32'(pixel_addr), 32'(pipe1.addr));
        check("layer_sel",  32'(layer_sel),  32'(pipe1.sel));
        check("notBlank",   32'(notBlank),   32'(pipe1.nb));
        check("out_valid",  32'(out_valid),  32'(pipe1.ov));
        check("coll_flag",  32'(coll_flag),  32'(m_flag));
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
        check("coll_count", 32'(coll_count), 32'(m_count));
`endif

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (frame_start) begin
                m_flag   = m_acc;
                m_acc    = overlap;
                m_count  = m_cnt;
                m_cnt    = overlap ? 1 : 0;
                m_en     = layer_en_next;
                m_blink  = blink_mask_next;
                m_frames = m_frames + 1;
            end else begin
                m_acc = m_acc | overlap;
                if (overlap && m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            pipe1 = pipe0;
            pipe0 = cur;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] a);
        layer_addr[idx*AW +: AW] = a;
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst             = 1'b1;
        frame_start     = 1'b0;
        pix_valid       = 1'b0;
        layer_hit       = '0;
        layer_addr      = '0;
        layer_en_next   = '1;
        blink_mask_next = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("reset_pixel_addr", 32'(pixel_addr), 32'd0);
        check("reset_layer_sel",  32'(layer_sel),  32'd0);
        check("reset_notBlank",   32'(notBlank),   32'd0);
        check("reset_out_valid",  32'(out_valid),  32'd0);
        check("reset_coll_flag",  32'(coll_flag),  32'd0);
        ticks(2);

        // Basic priority select: layers 2 and 3 hit, layer 2 wins
        rst       = 1'b0;
        pix_valid = 1'b1;
        rand_addrs();
        set_addr(2, 17'h00123);
        set_addr(3, 17'h00456);
        layer_hit = 6'b001100;
        ticks(3);
        check("basic_addr",  32'(pixel_addr), 32'h00123);
        check("basic_sel",   32'(layer_sel),  32'd2);
        check("basic_nb",    32'(notBlank),   32'd1);
        check("basic_valid", 32'(out_valid),  32'd1);

        // Enable change mid-frame waits for frame_start
        layer_en_next = 6'b111011;
        ticks(4);
        check("en_midframe_sel", 32'(layer_sel), 32'd2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks(3);
        check("en_applied_sel",  32'(layer_sel),  32'd3);
        check("en_applied_addr", 32'(pixel_addr), 32'h00456);

        // Blink on layer 0 with layers 0 and 5 hit every frame
        layer_en_next   = '1;
        blink_mask_next = 6'b000001;
        layer_hit       = 6'b100001;
        for (int f = 0; f < 36; f++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            ticks(3);
        end

        // Collision: four overlapping pixels in frame k, none in frame k+1
        blink_mask_next = '0;
        frame_start = 1'b1;
        layer_hit   = 6'b000010;
        tick();
        frame_start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            layer_hit = (p % 2 == 0) ? 6'b000110 : 6'b010010;
            tick();
        end
        frame_start = 1'b1;
        layer_hit   = 6'b000010;
        tick();
        frame_start = 1'b0;
        ticks(4);
        check("coll_frame_k1", 32'(coll_flag), 32'd1);
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
        check("coll_count_k1", 32'(coll_count), 32'd4);
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks(4);
        check("coll_frame_k2", 32'(coll_flag), 32'd0);
`ifdef LAYER_COMPOSITOR_COLL_COUNT_EN
        check("coll_count_k2", 32'(coll_count), 32'd0);
`endif

        // Invalid pixels with every layer hit produce blank, invalid output
        pix_valid = 1'b0;
        layer_hit = '1;
        ticks(3);
        check("invalid_valid", 32'(out_valid),  32'd0);
        check("invalid_nb",    32'(notBlank),   32'd0);
        check("invalid_addr",  32'(pixel_addr), 32'd0);

        // Reset mid-frame with an overlap already accumulated
        pix_valid   = 1'b1;
        layer_hit   = 6'b000110;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        check("rst_mid_addr",  32'(pixel_addr), 32'd0);
        check("rst_mid_sel",   32'(layer_sel),  32'd0);
        check("rst_mid_nb",    32'(notBlank),   32'd0);
        check("rst_mid_valid", 32'(out_valid),  32'd0);
        check("rst_mid_coll",  32'(coll_flag),  32'd0);
        rst       = 1'b0;
        layer_hit = 6'b001001;
        ticks(4);
        for (int f = 0; f < 2; f++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            ticks(4);
            check("rst_no_overlap_coll", 32'(coll_flag), 32'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 599) == 0);
            frame_start     = ($urandom_range(0, 15) == 0);
            pix_valid       = ($urandom_range(0, 3) != 0);
            layer_hit       = N'($urandom);
            layer_en_next   = N'($urandom | $urandom);
            blink_mask_next = N'($urandom & $urandom);
            rand_addrs();
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
